bus_arb2: RTL and testbench

//  Two-master to one-slave physical bus arbiter sitting directly downstream of mmu_sv32 (master 1).

---
 rtl/bus_arb2.sv | 138 +++++++++++++
 tb/tb_bus_arb2.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb2.sv
// bus_arb2 -- two-master to one-slave bus arbiter with hold-off release (hrd) and drain on owner drop.
// Rev 1.0
`default_nettype none

module bus_arb2 #(
  parameter bit          RR       = 1'b1,
  parameter int unsigned MIN_HOLD = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  output logic        m0_hrd_o,
  input  logic [31:0] m0_a_i,
  input  logic [31:0] m0_d_i,
  input  logic        m0_we_i,
  input  logic        m0_rd_i,
  output logic [31:0] m0_spo_o,
  output logic        m0_ready_o,
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  output logic        m1_hrd_o,
  input  logic [31:0] m1_a_i,
  input  logic [31:0] m1_d_i,
  input  logic        m1_we_i,
  input  logic        m1_rd_i,
  output logic [31:0] m1_spo_o,
  output logic        m1_ready_o,
  output logic [31:0] s_a_o,
  output logic [31:0] s_d_o,
  output logic        s_we_o,
  output logic        s_rd_o,
  input  logic [31:0] s_spo_i,
  input  logic        s_ready_i
);

  localparam logic [7:0] HOLD_THR = 8'(MIN_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        outst_q, outst_d;
  logic [7:0]  hold_q, hold_d;

  logic        in_grant;
  logic        own_req, oth_req, own_rd, own_we;
  logic [31:0] own_a, own_d;
  logic        busy, rdy_ok, hold_ok;

  always_comb begin
    own_req = owner_q ? m1_req_i : m0_req_i;
    oth_req = owner_q ? m0_req_i : m1_req_i;
    own_rd  = owner_q ? m1_rd_i  : m0_rd_i;
    own_we  = owner_q ? m1_we_i  : m0_we_i;
    own_a   = owner_q ? m1_a_i   : m0_a_i;
    own_d   = owner_q ? m1_d_i   : m0_d_i;
  end

  assign in_grant = (state_q == GRANT);

  // Only the owner reaches the slave; non-owner strobes are simply lost.
  assign s_rd_o = in_grant & own_rd;
  assign s_we_o = in_grant & own_we;
  assign s_a_o  = in_grant ? own_a : '0;
  assign s_d_o  = in_grant ? own_d : '0;

  assign busy    = outst_q | s_rd_o | s_we_o;
  assign outst_d = busy & ~s_ready_i;
  assign rdy_ok  = s_ready_i & busy & (state_q != IDLE);
  assign hold_ok = (hold_q >= HOLD_THR);

  assign m0_gnt_o   = in_grant & ~owner_q;
  assign m1_gnt_o   = in_grant &  owner_q;
  assign m0_hrd_o   = m0_gnt_o & m1_req_i & hold_ok;
  assign m1_hrd_o   = m1_gnt_o & m0_req_i & hold_ok;
  assign m0_ready_o = rdy_ok & ~owner_q;
  assign m1_ready_o = rdy_ok &  owner_q;
  assign m0_spo_o   = owner_q ? '0 : s_spo_i;
  assign m1_spo_o   = owner_q ? s_spo_i : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (m0_req_i | m1_req_i) begin
          state_d = GRANT;
          hold_d  = '0;
          if (m0_req_i & m1_req_i) owner_d = RR ? ~last_q : 1'b0;
          else                     owner_d = m1_req_i;
        end
      end
      GRANT: begin
        if (own_req) begin
          if (hold_q != 8'hFF) hold_d = hold_q + 8'd1;
        end else begin
          last_d = owner_q;
          hold_d = '0;
          // Owner cannot change while the slave still owes a completion.
          if (outst_d)      state_d = DRAIN;
          else if (oth_req) owner_d = ~owner_q;
          else              state_d = IDLE;
        end
      end
      DRAIN: begin
        if (s_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      outst_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      outst_q <= outst_d;
      hold_q  <= hold_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_arb2.sv
// tb_bus_arb2 -- round-robin and fixed-priority instances driven in parallel, checked against a transaction model.
`default_nettype none

module tb_bus_arb2;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req, rd, we;
  logic [31:0] a [2];
  logic [31:0] d [2];
  logic        s_ready;
  logic [31:0] s_spo;

  int n_checks = 0;
  int n_err    = 0;

  // own: master currently granted (-1 none); sel: most recent grantee (routes spo/drain ready)
  typedef struct {
    int own;
    bit drn;
    int sel;
    int prev;
    bit pend;
    int held;
  } mdl_t;

  mdl_t m_rr, m_fp;
  localparam mdl_t MDL_RST = '{own: -1, drn: 1'b0, sel: 0, prev: 1, pend: 1'b0, held: 0};

  logic        rr_g0, rr_g1, rr_h0, rr_h1, rr_r0, rr_r1, rr_srd, rr_swe;
  logic [31:0] rr_sp0, rr_sp1, rr_sa, rr_sd;
  logic        fp_g0, fp_g1, fp_h0, fp_h1, fp_r0, fp_r1, fp_srd, fp_swe;
  logic [31:0] fp_sp0, fp_sp1, fp_sa, fp_sd;
  logic [135:0] obs_rr, obs_fp;

  assign obs_rr = {rr_g1, rr_g0, rr_h1, rr_h0, rr_r1, rr_r0, rr_srd, rr_swe, rr_sp0, rr_sp1, rr_sa, rr_sd};
  assign obs_fp = {fp_g1, fp_g0, fp_h1, fp_h0, fp_r1, fp_r0, fp_srd, fp_swe, fp_sp0, fp_sp1, fp_sa, fp_sd};

  bus_arb2 #(.RR(1'b1), .MIN_HOLD(HOLD)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(req[0]), .m0_gnt_o(rr_g0), .m0_hrd_o(rr_h0), .m0_a_i(a[0]), .m0_d_i(d[0]),
    .m0_we_i(we[0]), .m0_rd_i(rd[0]), .m0_spo_o(rr_sp0), .m0_ready_o(rr_r0),
    .m1_req_i(req[1]), .m1_gnt_o(rr_g1), .m1_hrd_o(rr_h1), .m1_a_i(a[1]), .m1_d_i(d[1]),
    .m1_we_i(we[1]), .m1_rd_i(rd[1]), .m1_spo_o(rr_sp1), .m1_ready_o(rr_r1),
    .s_a_o(rr_sa), .s_d_o(rr_sd), .s_we_o(rr_swe), .s_rd_o(rr_srd),
    .s_spo_i(s_spo), .s_ready_i(s_ready)
  );

  bus_arb2 #(.RR(1'b0), .MIN_HOLD(HOLD)) u_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(req[0]), .m0_gnt_o(fp_g0), .m0_hrd_o(fp_h0), .m0_a_i(a[0]), .m0_d_i(d[0]),
    .m0_we_i(we[0]), .m0_rd_i(rd[0]), .m0_spo_o(fp_sp0), .m0_ready_o(fp_r0),
    .m1_req_i(req[1]), .m1_gnt_o(fp_g1), .m1_hrd_o(fp_h1), .m1_a_i(a[1]), .m1_d_i(d[1]),
    .m1_we_i(we[1]), .m1_rd_i(rd[1]), .m1_spo_o(fp_sp1), .m1_ready_o(fp_r1),
    .s_a_o(fp_sa), .s_d_o(fp_sd), .s_we_o(fp_swe), .s_rd_o(fp_srd),
    .s_spo_i(s_spo), .s_ready_i(s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the current inputs, from the model's view of who holds the bus.
  task automatic mdl_comb(input mdl_t m, output logic [135:0] e);
    logic g0, g1, h0, h1, r0, r1, srd, swe, busy;
    logic [31:0] sa, sd, sp0, sp1;
    g0 = (m.own == 0);
    g1 = (m.own == 1);
    h0 = g0 && req[1] && (m.held >= HOLD - 1);
    h1 = g1 && req[0] && (m.held >= HOLD - 1);
    srd = 1'b0; swe = 1'b0; sa = '0; sd = '0;
    if (m.own >= 0) begin
      srd = rd[m.own]; swe = we[m.own]; sa = a[m.own]; sd = d[m.own];
    end
    busy = m.pend || srd || swe;
    r0 = s_ready && busy && (g0 || (m.drn && m.sel == 0));
    r1 = s_ready && busy && (g1 || (m.drn && m.sel == 1));
    sp0 = (m.sel == 0) ? s_spo : 32'h0;
    sp1 = (m.sel == 1) ? s_spo : 32'h0;
    e = {g1, g0, h1, h0, r1, r0, srd, swe, sp0, sp1, sa, sd};
  endtask

  task automatic mdl_seq(input bit rr, inout mdl_t m);
    bit strobe, pn;
    int o, w;
    strobe = (m.own >= 0) && (rd[m.own] || we[m.own]);
    pn = (m.pend || strobe) && !s_ready;
    if (m.drn) begin
      if (s_ready) m.drn = 1'b0;
    end else if (m.own < 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) w = rr ? 1 - m.prev : 0;
        else              w = req[1] ? 1 : 0;
        m.own = w; m.sel = w; m.held = 0;
      end
    end else if (req[m.own]) begin
      m.held = (m.held < 255) ? m.held + 1 : 255;
    end else begin
      o = m.own;
      m.prev = o;
      m.held = 0;
      if (pn)             begin m.drn = 1'b1; m.own = -1; end
      else if (req[1-o])  begin m.own = 1 - o; m.sel = 1 - o; end
      else                m.own = -1;
    end
    m.pend = pn;
  endtask

  task automatic check_unit(input string u, input logic [135:0] o, input logic [135:0] e);
    chk({u, "_gnt"}, {30'd0, o[135:134]}, {30'd0, e[135:134]});
    chk({u, "_hrd"}, {30'd0, o[133:132]}, {30'd0, e[133:132]});
    chk({u, "_ready"}, {30'd0, o[131:130]}, {30'd0, e[131:130]});
    chk({u, "_strobe"}, {30'd0, o[129:128]}, {30'd0, e[129:128]});
    chk({u, "_m0_spo"}, o[127:96], e[127:96]);
    chk({u, "_m1_spo"}, o[95:64], e[95:64]);
    chk({u, "_s_a"}, o[63:32], e[63:32]);
    chk({u, "_s_d"}, o[31:0], e[31:0]);
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    logic [135:0] e;
    #1;
    mdl_comb(m_rr, e); check_unit("rr", obs_rr, e);
    mdl_comb(m_fp, e); check_unit("fp", obs_fp, e);
    @(posedge clk);
    mdl_seq(1'b1, m_rr);
    mdl_seq(1'b0, m_fp);
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    req = '0; rd = '0; we = '0;
    a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
    s_ready = 1'b0; s_spo = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    @(posedge clk);
    @(negedge clk);
    chk("rst_rr_ctl", {24'd0, obs_rr[135:128]}, 32'd0);
    chk("rst_fp_ctl", {24'd0, obs_fp[135:128]}, 32'd0);
    chk("rst_s_a", rr_sa, 32'd0);
    rst_n = 1'b1;
    m_rr = MDL_RST;
    m_fp = MDL_RST;
  endtask

  // Reset pulled mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_rr_ctl", {24'd0, obs_rr[135:128]}, 32'd0);
    chk("arst_fp_ctl", {24'd0, obs_fp[135:128]}, 32'd0);
    chk("arst_s_a", {rr_sa | fp_sa}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    clr_inputs();
    rst_n = 1'b1;
    m_rr = MDL_RST;
    m_fp = MDL_RST;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    do_reset();

    // m1 alone, single read, slave answers three cycles later
    req = 2'b10; a[1] = 32'h8000_1000; step();
    rd[1] = 1'b1; step();
    rd[1] = 1'b0; step(); step();
    s_ready = 1'b1; s_spo = 32'hDEAD_BEEF;
    #1;
    chk("t1_m1_ready", {31'd0, rr_r1}, 32'd1);
    chk("t1_m1_spo", rr_sp1, 32'hDEAD_BEEF);
    chk("t1_m0_spo", rr_sp0, 32'd0);
    step();
    s_ready = 1'b0; s_spo = '0; req = 2'b00; step(); step();

    // simultaneous requests after reset, then direct hand-over
    do_reset();
    req = 2'b11; step(); step();
    chk("t2_m0_first", {30'd0, rr_g1, rr_g0}, 32'd1);
    req = 2'b10; step(); step(); step();
    req = 2'b00; step(); step();

    // hrd on the fourth grant cycle, then drain of an outstanding read
    do_reset();
    req = 2'b10; a[1] = 32'h0000_2000; step(); step();
    req = 2'b11; step(); step();
    #1 chk("t3_hrd_4th", {31'd0, rr_h1}, 32'd1);
    rd[1] = 1'b1; step();
    rd[1] = 1'b0; req = 2'b01; step(); step(); step();
    s_ready = 1'b1; step();
    s_ready = 1'b0; step(); step();
    req = 2'b00; step();

    // non-owner strobe is dropped
    do_reset();
    req = 2'b10; a[1] = 32'h0000_5555; d[1] = 32'h1234_5678; step(); step();
    a[0] = 32'h0000_1000; rd[0] = 1'b1; step();
    rd[0] = 1'b0; s_ready = 1'b1; step();
    s_ready = 1'b0; req = 2'b00; step(); step();

    // reset while draining, then a stray slave completion
    do_reset();
    req = 2'b01; step(); step();
    we[0] = 1'b1; step();
    we[0] = 1'b0; req = 2'b00; step();
    async_reset();
    step();
    s_ready = 1'b1; step();
    s_ready = 1'b0; step();

    // both requesting for long enough to saturate the hold counter
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 270; i++) step();
    req = 2'b10; step(); step();
    req = 2'b00; step(); step();

    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(7) == 0) req[k] = ~req[k];
        rd[k] = ($urandom_range(3) == 0);
        we[k] = !rd[k] && ($urandom_range(5) == 0);
        a[k]  = $urandom;
        d[k]  = $urandom;
      end
      s_ready = ($urandom_range(2) == 0);
      s_spo   = $urandom;
      if ($urandom_range(599) == 0) async_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
